// File: rtl/wo_reg_programmer.sv
// wo_reg_programmer
//   Programs one write-once register (payload in DATA_W-1:1, lock flag in
//   bit 0) through a plain write strobe / readback interface. Refuses to
//   write an already locked register, verifies every write after a settle
//   delay, and retries while the register is still unlocked.
//
// Ports
//   Clk, ip_resetn       clock (rising edge), async active-low reset
//   req                  program request, only looked at in IDLE
//   req_data, req_lock   payload (bit 0 ignored) and lock value to program
//   busy                 transaction in flight, through the done/error cycle
//   done, error          one-cycle completion pulses
//   err_code             00 ok, 01 already locked, 10 retries exhausted,
//                        11 locked with wrong data; held until next accept
//   reg_write            write strobe, high only in WRITE
//   reg_data_out         write data, holds between writes
//   reg_data_in          register readback
//
// state  | meaning
// IDLE   | waiting for req
// CHECK  | readback lock bit; locked register is never written
// WRITE  | single-cycle write strobe
// SETTLE | SETTLE_CYCLES quiet cycles before sampling the readback
// VERIFY | compare readback against the captured word
// DONE   | done pulse
// ERR    | error pulse, err_code already valid
module wo_reg_programmer #(
  parameter int DATA_W        = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int MAX_RETRY     = 3
) (
  input  logic              Clk,
  input  logic              ip_resetn,
  input  logic              req,
  input  logic [DATA_W-1:0] req_data,
  input  logic              req_lock,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              reg_write,
  output logic [DATA_W-1:0] reg_data_out,
  input  logic [DATA_W-1:0] reg_data_in
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_WRITE, ST_SETTLE, ST_VERIFY, ST_DONE, ST_ERR
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [2:0] RETRY_MAX   = 3'(MAX_RETRY);

  state_t            state, state_nxt;
  logic [DATA_W-1:0] cap_word;
  logic [3:0]        settle_cnt;
  logic [2:0]        retry_cnt;
  logic              settle_last;
  logic              match;
  logic              retry_ok;

  // The request's bit 0 is replaced by req_lock.
  logic unused_req_bit0;
  assign unused_req_bit0 = req_data[0];

  assign settle_last = (settle_cnt == SETTLE_LAST);
  assign match       = (reg_data_in == cap_word);
  assign retry_ok    = (retry_cnt < RETRY_MAX);

  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (req) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = reg_data_in[0] ? ST_ERR : ST_WRITE;
      ST_WRITE:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_last) state_nxt = ST_VERIFY;
      ST_VERIFY: begin
        if (match)               state_nxt = ST_DONE;
        else if (reg_data_in[0]) state_nxt = ST_ERR;
        else if (retry_ok)       state_nxt = ST_WRITE;
        else                     state_nxt = ST_ERR;
      end
      ST_DONE:   state_nxt = ST_IDLE;
      ST_ERR:    state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Decoded from state only, so reset removes the write strobe at once.
  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    error     = (state == ST_ERR);
    reg_write = (state == ST_WRITE);
  end

  always_ff @(posedge Clk or negedge ip_resetn) begin
    if (!ip_resetn) begin
      cap_word     <= '0;
      settle_cnt   <= '0;
      retry_cnt    <= '0;
      err_code     <= 2'b00;
      reg_data_out <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            cap_word  <= {req_data[DATA_W-1:1], req_lock};
            retry_cnt <= '0;
            err_code  <= 2'b00;
          end
        end
        ST_CHECK: begin
          if (reg_data_in[0]) err_code <= 2'b01;
        end
        ST_WRITE: begin
          settle_cnt <= '0;
        end
        ST_SETTLE: begin
          if (!settle_last) settle_cnt <= settle_cnt + 4'd1;
        end
        ST_VERIFY: begin
          if (!match) begin
            if (reg_data_in[0]) err_code  <= 2'b11;
            else if (retry_ok)  retry_cnt <= retry_cnt + 3'd1;
            else                err_code  <= 2'b10;
          end
        end
        default: ;
      endcase
      // Load write data only when a write is about to be issued, so the
      // bus keeps the last written word otherwise.
      if (state_nxt == ST_WRITE) reg_data_out <= cap_word;
    end
  end

endmodule

// File: tb/tb_wo_reg_programmer.sv
module tb_wo_reg_programmer;

  localparam int S = 2;
  localparam int R = 3;

  logic        Clk = 1'b0;
  logic        ip_resetn = 1'b0;
  logic        req = 1'b0;
  logic [15:0] req_data = '0;
  logic        req_lock = 1'b0;
  logic        busy, done, error, reg_write;
  logic [1:0]  err_code;
  logic [15:0] reg_data_out;
  logic [15:0] reg_data_in;

  int checks = 0;
  int failures = 0;

  wo_reg_programmer #(.DATA_W(16), .SETTLE_CYCLES(S), .MAX_RETRY(R)) dut (
    .Clk(Clk), .ip_resetn(ip_resetn), .req(req), .req_data(req_data),
    .req_lock(req_lock), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .reg_write(reg_write), .reg_data_out(reg_data_out),
    .reg_data_in(reg_data_in)
  );

  always #5 Clk = ~Clk;

  // Register model: mode 0 write-once, 1 ignores writes, 2 latches fixed value
  logic [15:0] reg_val = '0;
  logic        model_load = 1'b0;
  logic [15:0] model_init = '0;
  int          model_mode = 0;
  logic [15:0] model_fixed = '0;

  always @(posedge Clk) begin
    if (model_load) reg_val <= model_init;
    else if (reg_write) begin
      case (model_mode)
        0: if (!reg_val[0]) reg_val <= reg_data_out;
        2: reg_val <= model_fixed;
        default: ;
      endcase
    end
  end
  assign reg_data_in = reg_val;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Observations of the last transaction
  int          obs_wc_q[$];
  logic [15:0] obs_wd_q[$];
  int          obs_end;
  bit          obs_err;
  logic [1:0]  obs_code;
  bit          obs_busy_bad;
  logic        post_busy, post_pulse;
  logic [1:0]  post_code;

  int          exp_wc_q[$];

  task automatic set_reg(input logic [15:0] v, input int mode, input logic [15:0] fx);
    @(negedge Clk);
    model_init = v; model_mode = mode; model_fixed = fx; model_load = 1'b1;
    @(negedge Clk);
    model_load = 1'b0;
  endtask

  // Drives one request and records what the DUT did, cycle 1 being the
  // cycle right after the accepting edge.
  task automatic run_txn(input logic [15:0] d, input logic l);
    obs_wc_q.delete(); obs_wd_q.delete();
    obs_end = -1; obs_err = 0; obs_code = 2'b00; obs_busy_bad = 0;
    @(negedge Clk);
    req = 1'b1; req_data = d; req_lock = l;
    @(negedge Clk);
    req = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (c > 1) @(negedge Clk);
      if (busy !== 1'b1) obs_busy_bad = 1;
      if (reg_write === 1'b1) begin
        obs_wc_q.push_back(c);
        obs_wd_q.push_back(reg_data_out);
      end
      if (done === 1'b1 || error === 1'b1) begin
        obs_end = c; obs_err = error; obs_code = err_code;
        break;
      end
    end
    @(negedge Clk);
    post_busy = busy; post_pulse = done | error; post_code = err_code;
  endtask

  // Reference: walk through attempts with the register's abstract behaviour.
  task automatic predict(input logic [15:0] init, input int mode, input logic [15:0] fx,
                         input logic [15:0] word, output int e_end, output bit e_err,
                         output logic [1:0] e_code);
    logic [15:0] r;
    int t;
    r = init;
    exp_wc_q.delete();
    e_end = -1; e_err = 1; e_code = 2'b10;
    if (r[0]) begin
      e_end = 2; e_code = 2'b01;
      return;
    end
    t = 2;
    for (int a = 0; a <= R; a++) begin
      exp_wc_q.push_back(t);
      if (mode == 0) begin
        if (!r[0]) r = word;
      end else if (mode == 2) r = fx;
      if (r == word) begin
        e_end = t + S + 2; e_err = 0; e_code = 2'b00;
        return;
      end
      if (r[0]) begin
        e_end = t + S + 2; e_code = 2'b11;
        return;
      end
      if (a == R) begin
        e_end = t + S + 2; e_code = 2'b10;
        return;
      end
      t = t + S + 2;
    end
  endtask

  task automatic test_reset();
    ip_resetn = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, reg_write} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/error/reg_write=%b required 0000", {busy, done, error, reg_write});
    end
    checks++;
    if (err_code !== 2'b00 || reg_data_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_data: err_code=%b reg_data_out=%h required 00 0000", err_code, reg_data_out);
    end
    repeat (2) @(negedge Clk);
    ip_resetn = 1'b1;
  endtask

  task automatic test_program_ok();
    set_reg(16'h0000, 0, 16'h0000);
    run_txn(16'hA5A4, 1'b1);
    checks++;
    if (obs_wc_q.size() != 1 || obs_wc_q[0] != 2 || obs_wd_q[0] !== 16'hA5A5) begin
      failures++;
      $display("FAIL ok_write: writes=%0d first_cycle=%0d data=%h required 1 2 a5a5",
               obs_wc_q.size(), obs_wc_q.size() ? obs_wc_q[0] : -1, obs_wd_q.size() ? obs_wd_q[0] : 16'hxxxx);
    end
    checks++;
    if (obs_end != 6 || obs_err != 0 || obs_code !== 2'b00) begin
      failures++;
      $display("FAIL ok_done: end=%0d err=%0d code=%b required 6 0 00", obs_end, obs_err, obs_code);
    end
    checks++;
    if (obs_busy_bad || post_busy !== 1'b0 || post_pulse !== 1'b0) begin
      failures++;
      $display("FAIL ok_busy: busy_gap=%0d post_busy=%b post_pulse=%b required 0 0 0", obs_busy_bad, post_busy, post_pulse);
    end
  endtask

  task automatic test_already_locked();
    set_reg(16'h1235, 0, 16'h0000);
    run_txn(16'h4444, 1'b0);
    checks++;
    if (obs_wc_q.size() != 0) begin
      failures++;
      $display("FAIL locked_nowrite: writes=%0d required 0", obs_wc_q.size());
    end
    checks++;
    if (obs_end != 2 || obs_err != 1 || obs_code !== 2'b01) begin
      failures++;
      $display("FAIL locked_err: end=%0d err=%0d code=%b required 2 1 01", obs_end, obs_err, obs_code);
    end
    checks++;
    if (post_code !== 2'b01 || post_pulse !== 1'b0) begin
      failures++;
      $display("FAIL locked_hold: code=%b pulse=%b required 01 0", post_code, post_pulse);
    end
  endtask

  task automatic test_retry_exhaust();
    int exp_c;
    set_reg(16'h0000, 1, 16'h0000);
    run_txn(16'h1230, 1'b0);
    checks++;
    if (obs_wc_q.size() != 4) begin
      failures++;
      $display("FAIL retry_count: writes=%0d required 4", obs_wc_q.size());
    end
    foreach (obs_wc_q[i]) begin
      exp_c = 2 + 4 * i;
      checks++;
      if (obs_wc_q[i] != exp_c || obs_wd_q[i] !== 16'h1230) begin
        failures++;
        $display("FAIL retry_write%0d: cycle=%0d data=%h required %0d 1230", i, obs_wc_q[i], obs_wd_q[i], exp_c);
      end
    end
    checks++;
    if (obs_end != 18 || obs_err != 1 || obs_code !== 2'b10) begin
      failures++;
      $display("FAIL retry_err: end=%0d err=%0d code=%b required 18 1 10", obs_end, obs_err, obs_code);
    end
  endtask

  task automatic test_locked_wrong();
    set_reg(16'h0000, 2, 16'h0F01);
    run_txn(16'h1230, 1'b1);
    checks++;
    if (obs_wc_q.size() != 1) begin
      failures++;
      $display("FAIL wrong_writes: writes=%0d required 1", obs_wc_q.size());
    end
    checks++;
    if (obs_end != 6 || obs_err != 1 || obs_code !== 2'b11) begin
      failures++;
      $display("FAIL wrong_err: end=%0d err=%0d code=%b required 6 1 11", obs_end, obs_err, obs_code);
    end
  endtask

  task automatic test_reset_mid();
    bit pulse_seen;
    // abort in WRITE: strobe must fall with reset, not at the next edge
    set_reg(16'h0000, 0, 16'h0000);
    @(negedge Clk);
    req = 1'b1; req_data = 16'h5556; req_lock = 1'b0;
    @(negedge Clk);
    req = 1'b0;
    @(negedge Clk);
    ip_resetn = 1'b0;
    #1;
    checks++;
    if (reg_write !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_write: reg_write=%b busy=%b required 0 0", reg_write, busy);
    end
    @(negedge Clk);
    ip_resetn = 1'b1;
    // abort in SETTLE
    set_reg(16'h0000, 0, 16'h0000);
    @(negedge Clk);
    req = 1'b1; req_data = 16'h5556; req_lock = 1'b0;
    @(negedge Clk);
    req = 1'b0;
    repeat (2) @(negedge Clk);
    ip_resetn = 1'b0;
    #1;
    checks++;
    if (reg_write !== 1'b0 || busy !== 1'b0 || err_code !== 2'b00) begin
      failures++;
      $display("FAIL rst_settle: reg_write=%b busy=%b code=%b required 0 0 00", reg_write, busy, err_code);
    end
    pulse_seen = 0;
    repeat (3) begin
      @(negedge Clk);
      if (done !== 1'b0 || error !== 1'b0) pulse_seen = 1;
    end
    ip_resetn = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      if (done !== 1'b0 || error !== 1'b0) pulse_seen = 1;
    end
    checks++;
    if (pulse_seen) begin
      failures++;
      $display("FAIL rst_nopulse: pulse_seen=1 required 0");
    end
    set_reg(16'h0000, 0, 16'h0000);
    run_txn(16'h7778, 1'b1);
    checks++;
    if (obs_wc_q.size() != 1 || obs_wd_q[0] !== 16'h7779 || obs_end != 6 || obs_err != 0) begin
      failures++;
      $display("FAIL rst_recover: writes=%0d end=%0d err=%0d required 1 6 0", obs_wc_q.size(), obs_end, obs_err);
    end
  endtask

  task automatic test_back_to_back();
    logic        b [1:13];
    int          wc [$];
    logic [15:0] wd [$];
    int          n_done;
    int          n_low;
    set_reg(16'h0000, 0, 16'h0000);
    n_done = 0; n_low = 0;
    @(negedge Clk);
    req = 1'b1; req_data = 16'hA5A4; req_lock = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge Clk);
      if (c == 1) req_data = 16'hBEEE;
      b[c] = busy;
      if (busy !== 1'b1) n_low++;
      if (done === 1'b1) n_done++;
      if (reg_write === 1'b1) begin
        wc.push_back(c);
        wd.push_back(reg_data_out);
      end
    end
    req = 1'b0;
    checks++;
    if (n_low != 1 || b[7] !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap: low_cycles=%0d busy_c7=%b required 1 0", n_low, b[7]);
    end
    checks++;
    if (wc.size() != 2 || wc[0] != 2 || wc[1] != 9 || wd[0] !== 16'hA5A4 || wd[1] !== 16'hBEEE) begin
      failures++;
      $display("FAIL b2b_writes: n=%0d required 2 at cycles 2,9 data a5a4,beee", wc.size());
    end
    checks++;
    if (n_done != 2) begin
      failures++;
      $display("FAIL b2b_done: done_pulses=%0d required 2", n_done);
    end
    repeat (2) @(negedge Clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_random();
    logic [15:0] init, fx, d, word;
    logic        l;
    int          mode, e_end;
    bit          e_err;
    logic [1:0]  e_code;
    for (int n = 0; n < 24; n++) begin
      mode = $urandom_range(2, 0);
      init = 16'($urandom);
      if ($urandom_range(2, 0) != 0) init[0] = 1'b0;
      d = 16'($urandom);
      l = 1'($urandom);
      word = {d[15:1], l};
      fx = ($urandom_range(3, 0) == 0) ? word : 16'($urandom);
      predict(init, mode, fx, word, e_end, e_err, e_code);
      set_reg(init, mode, fx);
      run_txn(d, l);
      checks++;
      if (obs_end != e_end || obs_err != e_err || obs_code !== e_code) begin
        failures++;
        $display("FAIL rnd%0d_end: end=%0d err=%0d code=%b required %0d %0d %b (mode %0d init %h word %h)",
                 n, obs_end, obs_err, obs_code, e_end, e_err, e_code, mode, init, word);
      end
      checks++;
      if (obs_wc_q.size() != exp_wc_q.size()) begin
        failures++;
        $display("FAIL rnd%0d_nwr: writes=%0d required %0d", n, obs_wc_q.size(), exp_wc_q.size());
      end else begin
        foreach (obs_wc_q[i]) begin
          checks++;
          if (obs_wc_q[i] != exp_wc_q[i] || obs_wd_q[i] !== word) begin
            failures++;
            $display("FAIL rnd%0d_wr%0d: cycle=%0d data=%h required %0d %h",
                     n, i, obs_wc_q[i], obs_wd_q[i], exp_wc_q[i], word);
          end
        end
      end
      checks++;
      if (obs_busy_bad || post_busy !== 1'b0 || post_pulse !== 1'b0 || post_code !== e_code) begin
        failures++;
        $display("FAIL rnd%0d_post: busy_gap=%0d busy=%b pulse=%b code=%b required 0 0 0 %b",
                 n, obs_busy_bad, post_busy, post_pulse, post_code, e_code);
      end
    end
  endtask

  initial begin
    test_reset();
    test_program_ok();
    test_already_locked();
    test_retry_exhaust();
    test_locked_wrong();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wo_reg_programmer.md
Name: wo_reg_programmer

Overview:
Initiator-side sequencer that programs one write-once register (16-bit data, lock flag in bit 0) over its simple write/readback interface.
- Takes a program request and first checks the lock state.
- Issues a single-cycle write, waits for the readback to settle, then verifies data and lock.
- Retries on a verify mismatch while the register is still unlocked; reports done or a coded error.
- Sits between the configuration/boot controller and the protected register.

Parameters:
DATA_W, 16, register width; bit 0 is the lock flag, bits DATA_W-1:1 are payload
SETTLE_CYCLES, 2, idle cycles between write pulse and readback sample; legal range 1..15
MAX_RETRY, 3, additional write attempts after a failed verify; legal range 0..7

Ports:
Clk  input  1  single clock, rising edge
ip_resetn  input  1  asynchronous active-low reset
req  input  1  program request, sampled in IDLE only
req_data  input  DATA_W  payload; bit 0 is ignored
req_lock  input  1  value to program into the lock bit
busy  output  1  high from the cycle after req is accepted until the done/error cycle, inclusive
done  output  1  one-cycle pulse: programmed and verified
error  output  1  one-cycle pulse: failed
err_code  output  2  00 ok, 01 already locked, 10 mismatch after retries, 11 locked with wrong data; held until next accept
reg_write  output  1  write strobe to the register
reg_data_out  output  DATA_W  write data to the register
reg_data_in  input  DATA_W  register readback; bit 0 is valid only after a non-write cycle

Behaviour:
- Reset (async, immediate): state IDLE; busy, done, error, reg_write = 0; err_code = 00; reg_data_out = 0; capture and retry registers cleared.
- FSM states: IDLE, CHECK, WRITE, SETTLE, VERIFY, DONE, ERR.
- IDLE: when req=1, capture {req_data[DATA_W-1:1], req_lock}, clear retry_cnt, set err_code=00, go to CHECK.
- CHECK (1 cycle, reg_write=0): if reg_data_in[0]=1, go to ERR with err_code 01; else go to WRITE.
- WRITE (1 cycle): reg_write=1, reg_data_out = captured word; go to SETTLE with settle counter = 0.
- SETTLE: reg_write=0; stay until the counter reaches SETTLE_CYCLES-1, then go to VERIFY.
- VERIFY (1 cycle) compares readback with the captured word:
  - full match: go to DONE.
  - mismatch and reg_data_in[0]=1: go to ERR, code 11, no retry.
  - mismatch, unlocked, retry_cnt<MAX_RETRY: retry_cnt+1, go to WRITE.
  - otherwise: go to ERR, code 10.
- DONE/ERR: assert done or error for exactly 1 cycle, busy=1, then return to IDLE. req is ignored in every state except IDLE. A continuously high req starts the next transaction one IDLE cycle later.
- reg_data_out holds its last value when reg_write=0; reg_write is high only in WRITE. A write on a locked register is never issued.
- Latency, first-try success, SETTLE_CYCLES=S: req sampled at edge 0 → CHECK at 1, WRITE at 2, VERIFY at 3+S, done high in cycle 4+S (cycle 6 at the default).
- Each retry adds S+2 cycles.
- Reset mid-operation: FSM aborts with no done/error pulse, and reg_write drops asynchronously.
- Counter widths: settle counter 4 bits, retry_cnt 3 bits. Neither counter wraps, because the parameter ranges bound them.

Test Plan:
1. Register unlocked (readback 0x0000); req with req_data=0xA5A4, req_lock=1 → exactly one reg_write pulse carrying 0xA5A5; model readback 0xA5A5; done in cycle 6; err_code=00; busy low after.
2. Readback 0x1235 (locked) on req → no reg_write ever; error pulse in cycle 2; err_code=01.
3. Model ignores writes (readback stays 0x0000); req_data=0x1230, req_lock=0 → 4 write pulses spaced 4 cycles apart; error with err_code=10 in cycle 18.
4. Model latches 0x0F01 while req_data=0x1230, req_lock=1 → after the first verify, error with err_code=11; only one write pulse.
5. ip_resetn pulsed low during SETTLE → reg_write=0, busy=0 immediately; no done/error; next req programs normally.
6. req held high across two transactions with req_data changed to 0xBEEE after the first accept → second write carries 0xBEEE|req_lock, and busy drops for exactly one IDLE cycle between transactions.
